// File: rtl/layer2_pkg.sv
// rtl/layer2_pkg.sv - shared constants and types for the layer-2 window reader
//
// Purpose: default geometry of the layer-2 feature map, the window element
// count and the reader FSM state type.
// Ports: none (package).
package layer2_pkg;

  localparam int L2_DATA_W = 128;
  localparam int L2_IMG_W  = 30;
  localparam int L2_IMG_H  = 30;
  localparam int L2_CNT_W  = 5;

  // Number of pixels in one 3x3 window.
  localparam int WIN_K = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/layer2_line_shift.sv
// rtl/layer2_line_shift.sv - enable-gated pixel shift chain with flat tap bus
//
// Purpose: DEPTH-entry delay line of DATA_W-bit pixels that advances only
// when i_en is high. Entry 0 (o_chain[DATA_W-1:0]) is the newest pixel.
// Ports:
//   i_clk   rising-edge clock
//   i_rst   asynchronous active-high reset, clears every entry
//   i_en    shift enable (one accepted pixel)
//   i_data  pixel shifted into entry 0
//   o_chain all entries, entry n at [n*DATA_W +: DATA_W]
module layer2_line_shift #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic [DATA_W-1:0]       i_data,
  output logic [DEPTH*DATA_W-1:0] o_chain
);

  logic [DEPTH*DATA_W-1:0] r_chain;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain <= '0;
    end else if (i_en) begin
      r_chain <= {r_chain[(DEPTH-1)*DATA_W-1:0], i_data};
    end
  end

  assign o_chain = r_chain;

endmodule

// File: rtl/layer2_window_reader.sv
// rtl/layer2_window_reader.sv - raster pixel stream to 3x3 window emitter
//
// Purpose: accepts one pixel per beat in raster order during a frame and
// emits every full 3x3 window, one cycle after the pixel completing it.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_start             frame start pulse, honoured only in IDLE
//   i_in_valid/i_in_data pixel stream input; o_in_ready high in RUN
//   o_win_valid         one-cycle pulse per window
//   o_win_data          element k=3*i+j at [k*DATA_W +: DATA_W] = pixel (r-2+i, c-2+j)
//   o_win_row/o_win_col top-left coordinate of the window
//   o_frame_done        one-cycle pulse after the frame's last window
//   o_busy              state is not IDLE
module layer2_window_reader
  import layer2_pkg::*;
#(
  parameter int DATA_W = L2_DATA_W,
  parameter int IMG_W  = L2_IMG_W,
  parameter int IMG_H  = L2_IMG_H,
  parameter int CNT_W  = L2_CNT_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_in_valid,
  input  logic [DATA_W-1:0]         i_in_data,
  output logic                      o_in_ready,
  output logic                      o_win_valid,
  output logic [WIN_K*DATA_W-1:0]   o_win_data,
  output logic [CNT_W-1:0]          o_win_row,
  output logic [CNT_W-1:0]          o_win_col,
  output logic                      o_frame_done,
  output logic                      o_busy
);

  localparam int DEPTH = 2*IMG_W + 3;
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W-1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H-1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [CNT_W-1:0]          r_row;
  logic [CNT_W-1:0]          r_col;
  logic                      r_win_valid;
  logic [WIN_K*DATA_W-1:0]   r_win_data;
  logic [CNT_W-1:0]          r_win_row;
  logic [CNT_W-1:0]          r_win_col;
  logic                      r_frame_done;

  logic                      w_in_ready;
  logic                      w_busy;
  logic                      w_in_done;
  logic                      w_accept;
  logic                      w_col_last;
  logic                      w_last_pix;
  logic                      w_win_hit;
  logic [DEPTH*DATA_W-1:0]   w_chain;
  logic [DEPTH*DATA_W-1:0]   w_next_chain;
  logic [WIN_K*DATA_W-1:0]   w_taps;
  logic                      w_unused;

  assign w_accept   = i_in_valid && w_in_ready;
  assign w_col_last = (r_col == COL_LAST);
  assign w_last_pix = w_col_last && (r_row == ROW_LAST);
  assign w_win_hit  = (r_row >= TWO) && (r_col >= TWO);

  layer2_line_shift #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_line_shift (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (w_accept),
    .i_data  (i_in_data),
    .o_chain (w_chain)
  );

  // The window is registered on the accepting edge, so tap the value the
  // chain is about to load (current chain shifted with the incoming pixel).
  assign w_next_chain = {w_chain[(DEPTH-1)*DATA_W-1:0], i_in_data};

  for (genvar k = 0; k < WIN_K; k++) begin : g_tap
    localparam int TI = k / 3;
    localparam int TJ = k % 3;
    localparam int TE = (2 - TI) * IMG_W + (2 - TJ);
    assign w_taps[k*DATA_W +: DATA_W] = w_next_chain[TE*DATA_W +: DATA_W];
  end

  // Only a subset of chain entries are window taps; the rest are pure delay.
  assign w_unused = ^w_next_chain ^ ^w_chain[DEPTH*DATA_W-1 -: DATA_W];

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = RUN;
      RUN:     if (w_accept && w_last_pix) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_in_ready = 1'b0;
    w_busy     = 1'b1;
    w_in_done  = 1'b0;
    case (r_state)
      IDLE:    w_busy     = 1'b0;
      RUN:     w_in_ready = 1'b1;
      DONE:    w_in_done  = 1'b1;
      default: w_busy     = 1'b0;
    endcase
  end

  // Frame position counters and window output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_row        <= '0;
      r_col        <= '0;
      r_win_valid  <= 1'b0;
      r_win_data   <= '0;
      r_win_row    <= '0;
      r_win_col    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      // DONE coincides with the last window pulse; delay the done pulse so
      // it lands strictly after it.
      r_frame_done <= w_in_done;
      r_win_valid  <= 1'b0;
      if (r_state == IDLE && i_start) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_accept) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_last_pix ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (w_win_hit) begin
          r_win_valid <= 1'b1;
          r_win_data  <= w_taps;
          r_win_row   <= r_row - TWO;
          r_win_col   <= r_col - TWO;
        end
      end
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_busy       = w_busy;
  assign o_win_valid  = r_win_valid;
  assign o_win_data   = r_win_data;
  assign o_win_row    = r_win_row;
  assign o_win_col    = r_win_col;
  assign o_frame_done = r_frame_done;

endmodule
